tug_match_ctrl: RTL

//   Match referee for the tug-of-war game. Watches the two playfield edge lights
//   and the players' key pulses, and awards points. It keeps both scores and

---
 rtl/tug_pkg.sv | 9 +
 rtl/tug_match_ctrl_if.sv | 28 ++
 rtl/pause_timer.sv | 33 +++
 rtl/tug_match_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and default constants for the tug-of-war match referee.
package tug_pkg;

  typedef enum logic [1:0] {PLAY, PAUSE, OVER} match_state_t;

  localparam int WIN_SCORE_D    = 7;
  localparam int PAUSE_CYCLES_D = 4;

endpackage

// File: rtl/tug_match_ctrl_if.sv
// Key/light inputs and score/sequencing outputs of the match referee.
interface tug_match_ctrl_if #(
  parameter int SCORE_W = 3
);

  logic               L;
  logic               R;
  logic               ledr9;
  logic               ledr1;
  logic               field_reset;
  logic               point_l;
  logic               point_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               win_l;
  logic               win_r;

  modport master (
    input  L, R, ledr9, ledr1,
    output field_reset, point_l, point_r, score_l, score_r, win_l, win_r
  );

  modport slave (
    output L, R, ledr9, ledr1,
    input  field_reset, point_l, point_r, score_l, score_r, win_l, win_r
  );

endinterface

// File: rtl/pause_timer.sv
// Registered down-counter for the post-point pause; done marks the terminal cycle.
module pause_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt_q == '0) begin
        busy <= 1'b0;
      end else begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign done = busy && (cnt_q == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// Match referee: decodes hits, keeps scores, sequences play / pause / game-over.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_D,
  parameter int SCORE_W      = 3,
  parameter int PAUSE_CYCLES = PAUSE_CYCLES_D,
  parameter int PCNT_W       = $clog2(PAUSE_CYCLES + 1)
) (
  input logic               clk,
  input logic               reset,
  tug_match_ctrl_if.master  bus
);

  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [PCNT_W-1:0]  PAUSE_LOAD = PCNT_W'(PAUSE_CYCLES - 1);

  match_state_t       state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               point_l_q, point_l_d;
  logic               point_r_q, point_r_d;
  logic               win_l_q, win_l_d;
  logic               win_r_q, win_r_d;
  logic               fr_q, fr_d;

  logic               hit_l, hit_r;
  logic [SCORE_W-1:0] sc_inc;
  logic               tmr_load, tmr_busy, tmr_done;

  assign hit_l  = bus.ledr9 & bus.L;
  assign hit_r  = bus.ledr1 & bus.R;
  assign sc_inc = (hit_l ? score_l_q : score_r_q) + SCORE_W'(1);

  pause_timer #(
    .W(PCNT_W)
  ) u_pause_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (PAUSE_LOAD),
    .busy     (tmr_busy),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    win_l_d   = win_l_q;
    win_r_d   = win_r_q;
    fr_d      = fr_q;
    tmr_load  = 1'b0;

    case (state_q)
      PLAY: begin
        fr_d = 1'b0;
        // Simultaneous hits cancel: nobody scores and play continues.
        if (hit_l ^ hit_r) begin
          fr_d = 1'b1;
          if (hit_l) begin
            score_l_d = sc_inc;
            point_l_d = 1'b1;
          end else begin
            score_r_d = sc_inc;
            point_r_d = 1'b1;
          end
          if (sc_inc == WIN_S) begin
            state_d = OVER;
            win_l_d = hit_l;
            win_r_d = hit_r;
          end else begin
            state_d  = PAUSE;
            tmr_load = 1'b1;
          end
        end
      end

      PAUSE: begin
        fr_d = 1'b1;
        // An idle timer here can only mean it was lost; fall back to play.
        if (tmr_done || !tmr_busy) begin
          state_d = PLAY;
          fr_d    = 1'b0;
        end
      end

      OVER: begin
        fr_d = 1'b1;
      end

      default: begin
        state_d = PLAY;
        fr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= PLAY;
      score_l_q <= '0;
      score_r_q <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      fr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      fr_q      <= fr_d;
    end
  end

  assign bus.field_reset = fr_q;
  assign bus.point_l     = point_l_q;
  assign bus.point_r     = point_r_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.win_l       = win_l_q;
  assign bus.win_r       = win_r_q;

endmodule
